pattern_det_ctrl: RTL and testbench
===================================

Name: pattern_det_ctrl

Overview:
Programmable serial pattern-detection controller for the pattern_detect family. It replaces fixed-pattern FSMs with a run-time configured matcher. Configuration (pattern, length, overlap mode, match limit) is loaded while idle. A run is then sequenced: the block scans a qualified serial bit stream, pulses on each match, counts matches and stops itself at a programmed limit.

Parameters:
MAXW, 8, maximum pattern length in bits (2..16)
CW, 8, width of the match counter and limit

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  reset, asynchronous, active-high
in_cfg_we  input  1  config write strobe
in_cfg_pat  input  MAXW  pattern; first-arriving bit compares to pat[len-1], last to pat[0]
in_cfg_len  input  clog2(MAXW)+1  pattern length
in_cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
in_cfg_limit  input  CW  match limit; 0 = unlimited
in_start  input  1  start a run
in_stop  input  1  abort or finish a run, return to IDLE
in_p  input  1  serial data bit
in_p_vld  input  1  in_p qualifier
o_match  output  1  one-cycle match pulse
o_count  output  CW  matches in current run
o_busy  output  1  high in ARMED
o_done  output  1  high in DONE
o_cfg_err  output  1  one-cycle pulse on rejected config write

Behaviour:
- Reset (async, in_rst=1): state IDLE. Pattern, len and limit regs are 0; ovl is 0. History and bit-count are 0. All outputs are 0.
- States:
  - IDLE → ARMED on in_start.
  - ARMED → DONE when a match makes count equal a nonzero limit.
  - ARMED → IDLE on in_stop.
  - DONE → IDLE on in_stop.
  - in_start in ARMED or DONE is ignored.
  - in_stop together with in_start: in_stop wins and the state is IDLE.
- Config:
  - in_cfg_we is accepted only in IDLE with 1 ≤ len ≤ MAXW. All four fields latch together on that edge.
  - Otherwise, regs are unchanged and o_cfg_err pulses the next cycle.
  - in_cfg_we together with in_start in IDLE: config latches and the run starts with the new config.
- On entry to ARMED: history, bit-count and o_count clear to 0.
- Each ARMED cycle with in_p_vld=1:
  - history shifts left, inserting in_p at bit 0.
  - bit-count increments, saturating at MAXW.
  - Match condition: bit-count (after update) ≥ len and history[len-1:0] == pat[len-1:0].
- In ARMED, a cycle with in_p_vld=0 changes nothing.
- Match handling:
  - o_match is registered: it goes high for exactly one cycle, the cycle after the completing bit's edge.
  - o_count increments on that same edge and saturates at 2^CW-1.
  - Overlapping mode: history is retained.
  - Non-overlapping mode: bit-count clears to 0, so the next match needs len fresh bits.
- In IDLE and DONE, in_p is ignored. o_count holds its value until the next start or reset. o_match stays 0.
- o_busy = (state==ARMED) and o_done = (state==DONE), both registered state decodes.
- Asserting reset mid-run takes effect immediately: IDLE with all regs cleared. Config is lost.

Test Plan:
- Reset, then write pat=3'b101, len=3, ovl=1, limit=0, start, stream 1,0,1,0,1 (vld=1) → o_match pulses after bits 3 and 5; o_count=2; o_busy=1.
- Same with ovl=0 → one pulse after bit 3; o_count=1.
- pat=2'b11, len=2, ovl=1, limit=2, stream 1,1,1,1 → pulses after bits 2 and 3; o_done=1 next cycle; bit 4 ignored; o_count=2; in_stop → IDLE with o_done=0.
- Config write while ARMED, or with len=0 or len=MAXW+1 → o_cfg_err one-cycle pulse; a subsequent run uses the old pattern.
- pat=101 stream with in_p_vld=0 cycles interleaved between bits → identical match count as the gap-free stream. Then in_rst mid-pattern → all outputs 0 immediately; start without reconfig and stream 1,1 with len=0 config → no match.

Source files
------------

// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern-detection controller.
// Configuration (pattern, length, overlap mode, match limit) is loaded while
// idle. A run scans the qualified serial stream, pulses o_match on each hit,
// counts hits and parks in DONE when a nonzero limit is reached.
//
// Handshake: in_p is consumed only on a rising edge where in_p_vld=1 and the
// controller is ARMED; there is no back-pressure. in_cfg_we, in_start and
// in_stop are single-cycle strobes sampled on the rising edge.
module pattern_det_ctrl #(
  parameter int MAXW = 8,
  parameter int CW   = 8,
  localparam int LW  = $clog2(MAXW) + 1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_cfg_we,
  input  logic [MAXW-1:0] in_cfg_pat,
  input  logic [LW-1:0]   in_cfg_len,
  input  logic            in_cfg_ovl,
  input  logic [CW-1:0]   in_cfg_limit,
  input  logic            in_start,
  input  logic            in_stop,
  input  logic            in_p,
  input  logic            in_p_vld,
  output logic            o_match,
  output logic [CW-1:0]   o_count,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [MAXW-1:0] pat_q, pat_d;
  logic [LW-1:0]   len_q, len_d;
  logic            ovl_q, ovl_d;
  logic [CW-1:0]   limit_q, limit_d;
  logic [MAXW-1:0] hist_q, hist_d;
  logic [LW-1:0]   bitcnt_q, bitcnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic            match_q, match_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cfg_err_q, cfg_err_d;

  // Helper values shared by the next-state logic.
  logic            cfg_ok;
  logic [MAXW:0]   one_sh;
  logic [MAXW:0]   mask_full;
  logic [MAXW-1:0] mask;
  logic [MAXW-1:0] hist_shift;
  logic [LW-1:0]   bitcnt_inc;
  logic [CW-1:0]   count_inc;
  logic            is_hit;

  // Pattern compare: low len bits of the shifted history against the pattern.
  always_comb begin
    cfg_ok     = (state_q == S_IDLE) && (in_cfg_len != '0) &&
                 (in_cfg_len <= LW'(MAXW));
    one_sh     = {{MAXW{1'b0}}, 1'b1} << len_q;
    mask_full  = one_sh - {{MAXW{1'b0}}, 1'b1};
    mask       = mask_full[MAXW-1:0];
    hist_shift = {hist_q[MAXW-2:0], in_p};
    bitcnt_inc = (bitcnt_q == LW'(MAXW)) ? bitcnt_q : bitcnt_q + LW'(1);
    count_inc  = (&count_q) ? count_q : count_q + CW'(1);
    // A zero length (the reset value) never matches.
    is_hit     = (len_q != '0) && (bitcnt_inc >= len_q) &&
                 (((hist_shift ^ pat_q) & mask) == '0);
  end

  // Next-state, config latch, match/count update and output decodes.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    limit_d   = limit_q;
    hist_d    = hist_q;
    bitcnt_d  = bitcnt_q;
    count_d   = count_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;

    if (in_cfg_we) begin
      if (cfg_ok) begin
        pat_d   = in_cfg_pat;
        len_d   = in_cfg_len;
        ovl_d   = in_cfg_ovl;
        limit_d = in_cfg_limit;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_start && !in_stop) begin
          state_d  = S_ARMED;
          hist_d   = '0;
          bitcnt_d = '0;
          count_d  = '0;
        end
      end
      S_ARMED: begin
        if (in_stop) begin
          state_d = S_IDLE;
        end else if (in_p_vld) begin
          hist_d   = hist_shift;
          bitcnt_d = bitcnt_inc;
          if (is_hit) begin
            match_d = 1'b1;
            count_d = count_inc;
            // Non-overlapping: the next hit needs len fresh bits.
            if (!ovl_q) bitcnt_d = '0;
            if ((limit_q != '0) && (count_inc == limit_q)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (in_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ARMED);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset clears configuration too.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      limit_q   <= '0;
      hist_q    <= '0;
      bitcnt_q  <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      limit_q   <= limit_d;
      hist_q    <= hist_d;
      bitcnt_q  <= bitcnt_d;
      count_q   <= count_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign o_match   = match_q;
  assign o_count   = count_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl with hand-computed expectations.
module tb_pattern_det_ctrl;

  localparam int MAXW = 8;
  localparam int CW   = 8;
  localparam int LW   = $clog2(MAXW) + 1;

  logic            in_clk;
  logic            in_rst;
  logic            in_cfg_we;
  logic [MAXW-1:0] in_cfg_pat;
  logic [LW-1:0]   in_cfg_len;
  logic            in_cfg_ovl;
  logic [CW-1:0]   in_cfg_limit;
  logic            in_start;
  logic            in_stop;
  logic            in_p;
  logic            in_p_vld;
  logic            o_match;
  logic [CW-1:0]   o_count;
  logic            o_busy;
  logic            o_done;
  logic            o_cfg_err;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  pattern_det_ctrl #(.MAXW(MAXW), .CW(CW)) dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_cfg_we   (in_cfg_we),
    .in_cfg_pat  (in_cfg_pat),
    .in_cfg_len  (in_cfg_len),
    .in_cfg_ovl  (in_cfg_ovl),
    .in_cfg_limit(in_cfg_limit),
    .in_start    (in_start),
    .in_stop     (in_stop),
    .in_p        (in_p),
    .in_p_vld    (in_p_vld),
    .o_match     (o_match),
    .o_count     (o_count),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_cfg_err   (o_cfg_err)
  );

  // Clock
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic write_cfg(input logic [MAXW-1:0] pat, input logic [LW-1:0] len,
                           input logic ovl, input logic [CW-1:0] limit);
    in_cfg_we    = 1'b1;
    in_cfg_pat   = pat;
    in_cfg_len   = len;
    in_cfg_ovl   = ovl;
    in_cfg_limit = limit;
    tick();
    in_cfg_we = 1'b0;
  endtask

  task automatic start_run();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic stop_run();
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
  endtask

  // Send n bits (MSB of bits first); exp holds the expected o_match per bit.
  // With gap=1 a vld=0 cycle follows each bit and must show no match.
  task automatic run_stream(input string tag, input logic [15:0] bits,
                            input logic [15:0] exp, input int n, input logic gap);
    logic [31:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back({31'b0, exp[n-1-i]});
    for (int i = 0; i < n; i++) begin
      in_p     = bits[n-1-i];
      in_p_vld = 1'b1;
      tick();
      in_p_vld = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s_match_b%0d", tag, i + 1), {31'b0, o_match}, e);
      if (gap) begin
        in_p = ~in_p;
        tick();
        check($sformatf("%s_gap_b%0d", tag, i + 1), {31'b0, o_match}, 32'd0);
      end
    end
  endtask

  initial begin
    in_rst = 1'b1;
    in_cfg_we = 1'b0; in_cfg_pat = '0; in_cfg_len = '0; in_cfg_ovl = 1'b0;
    in_cfg_limit = '0; in_start = 1'b0; in_stop = 1'b0; in_p = 1'b0; in_p_vld = 1'b0;
    tick();
    tick();
    check("rst_match", {31'b0, o_match}, 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_done", {31'b0, o_done}, 32'd0);
    check("rst_cfg_err", {31'b0, o_cfg_err}, 32'd0);
    #2 in_rst = 1'b0;
    tick();

    // Overlapping 101
    write_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    check("t1_cfg_ok", {31'b0, o_cfg_err}, 32'd0);
    start_run();
    check("t1_busy_start", {31'b0, o_busy}, 32'd1);
    check("t1_count_start", 32'(o_count), 32'd0);
    run_stream("t1", 16'b10101, 16'b00101, 5, 1'b0);
    check("t1_count", 32'(o_count), 32'd2);
    check("t1_busy", {31'b0, o_busy}, 32'd1);
    stop_run();
    check("t1_busy_stop", {31'b0, o_busy}, 32'd0);
    check("t1_count_hold", 32'(o_count), 32'd2);

    // Non-overlapping 101
    write_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    start_run();
    check("t2_count_clr", 32'(o_count), 32'd0);
    run_stream("t2", 16'b10101, 16'b00100, 5, 1'b0);
    check("t2_count", 32'(o_count), 32'd1);
    stop_run();

    // Limit of 2 with pattern 11
    write_cfg(8'b11, 4'd2, 1'b1, 8'd2);
    start_run();
    run_stream("t3", 16'b1111, 16'b0110, 4, 1'b0);
    check("t3_done", {31'b0, o_done}, 32'd1);
    check("t3_busy", {31'b0, o_busy}, 32'd0);
    check("t3_count", 32'(o_count), 32'd2);
    stop_run();
    check("t3_done_stop", {31'b0, o_done}, 32'd0);

    // start with stop in IDLE: stop wins
    in_start = 1'b1; in_stop = 1'b1;
    tick();
    in_start = 1'b0; in_stop = 1'b0;
    check("ss_busy", {31'b0, o_busy}, 32'd0);

    // Rejected config writes
    start_run();
    write_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    check("t4_err_armed", {31'b0, o_cfg_err}, 32'd1);
    tick();
    check("t4_err_pulse", {31'b0, o_cfg_err}, 32'd0);
    stop_run();
    write_cfg(8'b101, 4'd0, 1'b1, 8'd0);
    check("t4_err_len0", {31'b0, o_cfg_err}, 32'd1);
    write_cfg(8'b101, 4'd9, 1'b1, 8'd0);
    check("t4_err_len9", {31'b0, o_cfg_err}, 32'd1);
    start_run();
    run_stream("t4", 16'b11, 16'b01, 2, 1'b0);
    check("t4_count_old", 32'(o_count), 32'd1);
    stop_run();

    // Gapped stream, then reset mid-pattern
    write_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    start_run();
    run_stream("t5", 16'b10101, 16'b00101, 5, 1'b1);
    check("t5_count", 32'(o_count), 32'd2);
    run_stream("t5b", 16'b10, 16'b00, 2, 1'b0);
    in_rst = 1'b1;
    #1;
    check("t5_rst_busy", {31'b0, o_busy}, 32'd0);
    check("t5_rst_count", 32'(o_count), 32'd0);
    check("t5_rst_match", {31'b0, o_match}, 32'd0);
    check("t5_rst_done", {31'b0, o_done}, 32'd0);
    tick();
    #2 in_rst = 1'b0;
    tick();
    start_run();
    check("t5_busy_nocfg", {31'b0, o_busy}, 32'd1);
    run_stream("t5c", 16'b11, 16'b00, 2, 1'b0);
    check("t5_count_nocfg", 32'(o_count), 32'd0);
    stop_run();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
